rv32_decode_stage: RTL and testbench
====================================

Name: rv32_decode_stage

Overview:
- Decode-stage front end of the RV32IM core, between fetch and register read/execute.
- Classifies each fetched instruction and selects its immediate format; this is the control side of the immediate generator (rv32_imm_gen is instantiated inside and driven by this block).
- Buffers the decoded result in a 2-entry skid buffer with valid/ready on both sides.
- Supports a pipeline flush from branch/jump resolution.

Parameters:
- XLEN, 32, data/address width (from pkg_rv32_types; fixed at 32).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries; drop the input beat this cycle.
- if_valid  in  1  fetch beat valid.
- if_ready  out  1  stage can accept a beat.
- if_pc  in  XLEN  PC of fetched instruction.
- if_instr  in  XLEN  fetched instruction word.
- id_valid  out  1  decoded beat valid.
- id_ready  in  1  downstream accepts.
- id_pc  out  XLEN  registered PC.
- id_instr  out  XLEN  registered instruction.
- id_imm  out  XLEN  sign-extended immediate.
- id_imm_type  out  imm_type_e  selected immediate format.
- id_has_imm  out  1  instruction uses an immediate.
- id_illegal  out  1  unrecognised opcode or inst[1:0] != 2'b11.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0, except if_ready=1.
  - id_imm_type=IMM_I.
  - Buffer state EMPTY.
- Classification is combinational on if_instr[6:0]:
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM -> IMM_I, has_imm=1.
  - 0100011 STORE -> IMM_S.
  - 1100011 BRANCH -> IMM_B.
  - 0110111 LUI, 0010111 AUIPC -> IMM_U.
  - 1101111 JAL -> IMM_J.
  - 0110011 OP (incl. M-ext) -> has_imm=0, imm_type=IMM_I, imm forced 0.
  - Any other opcode, or inst[1:0] != 11 -> illegal=1, has_imm=0, imm 0, imm_type IMM_I.
- Imm_gen is fed if_instr and the selected type; its result is captured with the beat, so all id_* outputs are registered (no combinational path from if_* to id_*).
- Latency: a beat accepted at edge N is presented on id_* from N+1 when the buffer was empty.
- Handshake:
  - Transfer on valid&ready.
  - id_* hold stable while id_valid=1 and id_ready=0.
  - if_ready is a registered signal equal to "skid entry empty"; there is no combinational path from id_ready to if_ready.
- State machine (main = output register, skid = overflow):
  - EMPTY: accept -> ONE (load main).
  - ONE, with accept and no drain -> FULL (load skid).
  - ONE, with accept and drain -> ONE (main reloads from input).
  - ONE, with drain only -> EMPTY.
  - FULL: if_ready=0. On drain, main <= skid -> ONE. No accept is possible.
- Order: strictly FIFO; the skid entry always precedes any new beat.
- Flush, highest priority:
  - Next edge -> EMPTY, id_valid=0, if_ready=1.
  - An input beat in the same cycle is dropped even if if_ready=1.
  - An output transfer in the same cycle still counts downstream.
- Reset mid-operation: immediate return to reset values; in-flight beats are lost.
- Data registers are not cleared by flush; only the valid bits are.

Optional Feature:
- Macro: RV32_DECODE_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0] and perf_illegal_cnt[31:0]:
  - perf_stall_cnt increments each cycle id_valid=1 and id_ready=0.
  - perf_illegal_cnt increments on each output transfer with id_illegal=1.
  - Both counters are cleared by rst only, not by flush, and wrap at 2^32.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- ADDI x1,x0,-1: if_instr=0xFFF00093, pc=0x100, id_ready=1 -> next cycle id_valid=1, id_imm=0xFFFFFFFF, IMM_I, has_imm=1, id_pc=0x100.
- Immediate formats, back-to-back with no stalls:
  - JAL 0x0080006F -> imm 0x00000008, IMM_J.
  - BEQ 0xFE000EE3 -> imm 0xFFFFFFFC, IMM_B.
  - LUI 0x123450B7 -> imm 0x12345000, IMM_U.
  - ADD 0x002081B3 -> has_imm=0, imm 0.
  - Throughput 1 beat/cycle.
- Backpressure: stream pcs 0x0,0x4,0x8,0xC with id_ready=0 for 3 cycles.
  - Exactly 2 accepted; if_ready=0 the cycle after the 2nd accept.
  - id_* stable across the stall.
  - On release, outputs 0x0,0x4,0x8,0xC in order with none lost.
- Flush in FULL with if_valid=1 -> next cycle id_valid=0, if_ready=1; the flushed and dropped pcs never appear on id_pc.
- Illegal: 0x00000000 and 0x0000007F -> id_illegal=1, id_imm=0. With RV32_DECODE_PERF_EN, perf_illegal_cnt=2 after both transfer.
- Async reset asserted mid-stall, between clock edges -> id_valid=0, if_ready=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// RV32IM decode-stage front end: opcode classification, immediate generation and a
// 2-entry skid buffer. Define RV32_DECODE_PERF_EN to add stall/illegal perf counters.

module rv32_imm_gen (
  input  logic [31:0] instr_i,
  input  logic [2:0]  imm_type_i,
  output logic [31:0] imm_o
);
  // Encodings: 0=I, 1=S, 2=B, 3=U, 4=J.
  always_comb begin
    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    case (imm_type_i)
      3'd0: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      3'd1: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'd2: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      3'd3: imm_o = {instr_i[31:12], 12'h000};
      3'd4: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'h0000_0000;
    endcase
  end
endmodule

module rv32_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_imm,
  output logic [2:0]  id_imm_type,
  output logic        id_has_imm,
`ifdef RV32_DECODE_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_illegal_cnt,
`endif
  output logic        id_illegal
);
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        has_imm;
    logic        illegal;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      main_q, skid_q, in_s;
  logic        if_ready_q, id_valid_q;
  logic [2:0]  type_s;
  logic        has_imm_s, illegal_s;
  logic [31:0] gen_imm_s;
  logic        accept_s, drain_s;
  logic        load_main_in_s, load_main_skid_s, load_skid_s;

  // Opcode classification; anything unrecognised is illegal with no immediate.
  always_comb begin
    type_s    = IMM_I;
    has_imm_s = 1'b0;
    illegal_s = 1'b0;
    if (if_instr[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (if_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
          type_s = IMM_I; has_imm_s = 1'b1;
        end
        7'b0100011: begin type_s = IMM_S; has_imm_s = 1'b1; end
        7'b1100011: begin type_s = IMM_B; has_imm_s = 1'b1; end
        7'b0110111, 7'b0010111: begin type_s = IMM_U; has_imm_s = 1'b1; end
        7'b1101111: begin type_s = IMM_J; has_imm_s = 1'b1; end
        7'b0110011: has_imm_s = 1'b0;
        default: illegal_s = 1'b1;
      endcase
    end
  end

  rv32_imm_gen u_imm_gen (
    .instr_i    (if_instr),
    .imm_type_i (type_s),
    .imm_o      (gen_imm_s)
  );

  assign in_s = '{pc: if_pc, instr: if_instr, imm: (has_imm_s ? gen_imm_s : 32'h0000_0000),
                  imm_type: type_s, has_imm: has_imm_s, illegal: illegal_s};

  assign accept_s = if_valid & if_ready_q & ~flush;
  assign drain_s  = id_valid_q & id_ready;

  // Buffer next-state and load selects; flush overrides everything.
  always_comb begin
    state_d          = state_q;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin state_d = ONE; load_main_in_s = 1'b1; end
          else state_d = EMPTY;
        end
        ONE: begin
          if (accept_s && !drain_s) begin state_d = FULL; load_skid_s = 1'b1; end
          else if (accept_s && drain_s) begin state_d = ONE; load_main_in_s = 1'b1; end
          else if (drain_s) state_d = EMPTY;
          else state_d = ONE;
        end
        FULL: begin
          if (drain_s) begin state_d = ONE; load_main_skid_s = 1'b1; end
          else state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and handshake registers; valid bits mirror the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= (state_d != FULL);
      id_valid_q <= (state_d != EMPTY);
    end
  end

  // Payload registers; flush leaves the data in place and only drops validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in_s) main_q <= in_s;
      else if (load_main_skid_s) main_q <= skid_q;
      else main_q <= main_q;
      if (load_skid_s) skid_q <= in_s;
      else skid_q <= skid_q;
    end
  end

  assign if_ready    = if_ready_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = main_q.pc;
  assign id_instr    = main_q.instr;
  assign id_imm      = main_q.imm;
  assign id_imm_type = main_q.imm_type;
  assign id_has_imm  = main_q.has_imm;
  assign id_illegal  = main_q.illegal;

`ifdef RV32_DECODE_PERF_EN
  logic [31:0] stall_cnt_q, illegal_cnt_q;

  // Perf counters: cleared by reset only, wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q   <= 32'd0;
      illegal_cnt_q <= 32'd0;
    end else begin
      if (id_valid_q && !id_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      else stall_cnt_q <= stall_cnt_q;
      if (drain_s && main_q.illegal) illegal_cnt_q <= illegal_cnt_q + 32'd1;
      else illegal_cnt_q <= illegal_cnt_q;
    end
  end

  assign perf_stall_cnt   = stall_cnt_q;
  assign perf_illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed self-checking bench for rv32_decode_stage: immediates, backpressure,
// flush, illegal opcodes and asynchronous reset.

module tb_rv32_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic        if_ready, id_valid, id_has_imm, id_illegal;
  logic [31:0] if_pc, if_instr, id_pc, id_instr, id_imm;
  logic [2:0]  id_imm_type;
`ifdef RV32_DECODE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_illegal_cnt;
`endif

  int passed = 0;
  int total  = 0;

  rv32_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_imm      (id_imm),
    .id_imm_type (id_imm_type),
    .id_has_imm  (id_has_imm),
`ifdef RV32_DECODE_PERF_EN
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_illegal_cnt (perf_illegal_cnt),
`endif
    .id_illegal  (id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_imm_type", {29'd0, id_imm_type}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Back-to-back immediate formats, no stalls
    id_ready = 1'b1;
    drive(1'b1, 32'h100, 32'hFFF0_0093);
    tick();
    chk("addi_valid", {31'd0, id_valid}, 32'd1);
    chk("addi_imm", id_imm, 32'hFFFF_FFFF);
    chk("addi_type", {29'd0, id_imm_type}, 32'd0);
    chk("addi_has_imm", {31'd0, id_has_imm}, 32'd1);
    chk("addi_pc", id_pc, 32'h100);
    drive(1'b1, 32'h104, 32'h0080_006F);
    tick();
    chk("jal_imm", id_imm, 32'h0000_0008);
    chk("jal_type", {29'd0, id_imm_type}, 32'd4);
    chk("jal_pc", id_pc, 32'h104);
    drive(1'b1, 32'h108, 32'hFE00_0EE3);
    tick();
    chk("beq_imm", id_imm, 32'hFFFF_FFFC);
    chk("beq_type", {29'd0, id_imm_type}, 32'd2);
    chk("beq_pc", id_pc, 32'h108);
    drive(1'b1, 32'h10C, 32'h1234_50B7);
    tick();
    chk("lui_imm", id_imm, 32'h1234_5000);
    chk("lui_type", {29'd0, id_imm_type}, 32'd3);
    chk("lui_valid", {31'd0, id_valid}, 32'd1);
    drive(1'b1, 32'h110, 32'h0020_81B3);
    tick();
    chk("add_has_imm", {31'd0, id_has_imm}, 32'd0);
    chk("add_imm", id_imm, 32'h0);
    chk("add_illegal", {31'd0, id_illegal}, 32'd0);
    chk("add_pc", id_pc, 32'h110);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain_empty", {31'd0, id_valid}, 32'd0);

    // Backpressure: two accepted, then stall, then FIFO release
    id_ready = 1'b0;
    drive(1'b1, 32'h0, 32'h0000_0013);
    tick();
    chk("bp1_pc", id_pc, 32'h0);
    chk("bp1_if_ready", {31'd0, if_ready}, 32'd1);
    drive(1'b1, 32'h4, 32'h0000_0013);
    tick();
    chk("bp2_if_ready", {31'd0, if_ready}, 32'd0);
    chk("bp2_pc", id_pc, 32'h0);
    drive(1'b1, 32'h8, 32'h0000_0013);
    tick();
    chk("bp3_pc_stable", id_pc, 32'h0);
    chk("bp3_instr_stable", id_instr, 32'h0000_0013);
    chk("bp3_valid", {31'd0, id_valid}, 32'd1);
    id_ready = 1'b1;
    tick();
    chk("rel1_pc", id_pc, 32'h4);
    chk("rel1_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("rel2_pc", id_pc, 32'h8);
    drive(1'b1, 32'hC, 32'h0000_0013);
    tick();
    chk("rel3_pc", id_pc, 32'hC);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("rel_empty", {31'd0, id_valid}, 32'd0);

    // Flush while FULL, then flush while EMPTY, with input beats present
    id_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h0000_0013);
    tick();
    drive(1'b1, 32'h204, 32'h0000_0013);
    tick();
    chk("pre_flush_full", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'h208, 32'h0000_0013);
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_if_ready", {31'd0, if_ready}, 32'd1);
    drive(1'b1, 32'h20C, 32'h0000_0013);
    tick();
    chk("flush_drop", {31'd0, id_valid}, 32'd0);
    flush = 1'b0;
    id_ready = 1'b1;
    drive(1'b1, 32'h300, 32'h0000_0013);
    tick();
    chk("post_flush_pc", id_pc, 32'h300);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("post_flush_empty", {31'd0, id_valid}, 32'd0);

    // Illegal encodings
    drive(1'b1, 32'h400, 32'h0000_0000);
    tick();
    chk("ill0_flag", {31'd0, id_illegal}, 32'd1);
    chk("ill0_imm", id_imm, 32'h0);
    drive(1'b1, 32'h404, 32'h0000_007F);
    tick();
    chk("ill7f_flag", {31'd0, id_illegal}, 32'd1);
    chk("ill7f_imm", id_imm, 32'h0);
    chk("ill7f_has_imm", {31'd0, id_has_imm}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
`ifdef RV32_DECODE_PERF_EN
    chk("perf_illegal_cnt", perf_illegal_cnt, 32'd2);
`endif

    // Async reset between edges during a stall
    id_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h0000_0013);
    tick();
    drive(1'b1, 32'h504, 32'h0000_0013);
    tick();
    chk("stall_full", {31'd0, if_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("async_rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("async_rst_pc", id_pc, 32'h0);
`ifdef RV32_DECODE_PERF_EN
    chk("async_rst_perf", perf_illegal_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("after_rst_valid", {31'd0, id_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
